memory_arbiter: RTL

Shares a single synchronous-read memory port between the five memory requesters exported by the port controller: sprite, background 0, background 1 and overlay reads, plus SPI flash writes. It performs round-robin arbitration, drives the shared memory port and returns a one-cycle ready pulse to the requester that owns each completed access. It sits between the port controller's memory ports and the graphics/flash RAM at top level, and issues up to one access per clock.

---
 rtl/memory_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one synchronous-read memory port
// between four read requesters (spcon, bg0, bg1, ov) and one write requester
// (fl). At most one access is granted per clock. The owner of each completed
// access receives a one-cycle ready pulse in the cycle after its grant.
module memory_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] spcon_memory_address,
  input  logic [ADDRESS_BITS-1:0] bg0_memory_address,
  input  logic [ADDRESS_BITS-1:0] bg1_memory_address,
  input  logic [ADDRESS_BITS-1:0] ov_memory_address,
  input  logic                    spcon_rvalid,
  input  logic                    bg0_rvalid,
  input  logic                    bg1_rvalid,
  input  logic                    ov_rvalid,
  output logic [BITS-1:0]         spcon_memory_data,
  output logic [BITS-1:0]         bg0_memory_data,
  output logic [BITS-1:0]         bg1_memory_data,
  output logic [BITS-1:0]         ov_memory_data,
  output logic                    spcon_rready,
  output logic                    bg0_rready,
  output logic                    bg1_rready,
  output logic                    ov_rready,
  input  logic [ADDRESS_BITS-1:0] fl_memory_address,
  input  logic [BITS-1:0]         fl_memory_data,
  input  logic                    fl_wvalid,
  output logic                    fl_wready,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [BITS-1:0]         mem_wdata,
  output logic                    mem_wr,
  input  logic [BITS-1:0]         mem_rdata
);

  localparam logic [2:0] ID_SP  = 3'd0;
  localparam logic [2:0] ID_BG0 = 3'd1;
  localparam logic [2:0] ID_BG1 = 3'd2;
  localparam logic [2:0] ID_OV  = 3'd3;
  localparam logic [2:0] ID_FL  = 3'd4;

  logic [4:0]              req_v;
  logic [4:0]              done;
  logic [4:0]              elig;
  logic                    grant_v;
  logic [2:0]              grant_id;
  logic [3:0]              cand;
  logic [ADDRESS_BITS-1:0] grant_addr;

  // Stage p1: access in flight (one cycle after its grant edge)
  logic                    vld_p1;
  logic [2:0]              pend_id_p1;
  logic [2:0]              last_p1;
  logic [ADDRESS_BITS-1:0] addr_hold_p1;
  logic [BITS-1:0]         wdata_hold_p1;

  assign req_v = {fl_wvalid, ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};

  // One-hot decode of the in-flight access; doubles as the ready vector and
  // the outstanding mask, since an access is outstanding exactly until the
  // end of its ready cycle.
  always_comb begin
    done = '0;
    for (int i = 0; i < 5; i++) begin
      done[i] = vld_p1 && (pend_id_p1 == 3'(i));
    end
  end

  // No grants while reset is held, so nothing is strobed into the RAM.
  assign elig = req_v & ~done & {5{RSTb}};

  // Round-robin search starting one past the last granted index.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = ID_SP;
    cand     = '0;
    for (int k = 0; k < 5; k++) begin
      cand = {1'b0, last_p1} + 4'd1 + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!grant_v && elig[cand[2:0]]) begin
        grant_v  = 1'b1;
        grant_id = cand[2:0];
      end
    end
  end

  // Address of the selected requester.
  always_comb begin
    grant_addr = spcon_memory_address;
    case (grant_id)
      ID_SP:   grant_addr = spcon_memory_address;
      ID_BG0:  grant_addr = bg0_memory_address;
      ID_BG1:  grant_addr = bg1_memory_address;
      ID_OV:   grant_addr = ov_memory_address;
      ID_FL:   grant_addr = fl_memory_address;
      default: grant_addr = spcon_memory_address;
    endcase
  end

  assign mem_wr      = grant_v && (grant_id == ID_FL);
  assign mem_address = grant_v ? grant_addr : addr_hold_p1;
  assign mem_wdata   = mem_wr ? fl_memory_data : wdata_hold_p1;

  assign spcon_rready = done[0];
  assign bg0_rready   = done[1];
  assign bg1_rready   = done[2];
  assign ov_rready    = done[3];
  assign fl_wready    = done[4];

  assign spcon_memory_data = mem_rdata;
  assign bg0_memory_data   = mem_rdata;
  assign bg1_memory_data   = mem_rdata;
  assign ov_memory_data    = mem_rdata;

  // Grant edge: record the owner of the access and the round-robin pointer.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      vld_p1     <= 1'b0;
      pend_id_p1 <= ID_SP;
      last_p1    <= ID_FL;
    end else begin
      vld_p1 <= grant_v;
      if (grant_v) begin
        pend_id_p1 <= grant_id;
        last_p1    <= grant_id;
      end
    end
  end

  // Idle-cycle values for the memory address and write data buses.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      addr_hold_p1  <= '0;
      wdata_hold_p1 <= '0;
    end else begin
      if (grant_v) addr_hold_p1 <= grant_addr;
      if (mem_wr) wdata_hold_p1 <= fl_memory_data;
    end
  end

endmodule
